ascii_operand_loader: RTL and testbench



---
 rtl/ascii_pkg.sv | 33 +++
 rtl/ascii_char_class.sv | 25 ++
 rtl/ascii_operand_loader.sv | 149 ++++++++++++++
 tb/tb_ascii_operand_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII operand loader and its keyboard helpers:
// parser states, ASCII character constants and error codes.
package ascii_pkg;

    // Operand accumulator width: holds two decimal digits (0..99)
    localparam int unsigned ACC_W = 7;
    localparam int unsigned ERR_W = 2;

    localparam logic [7:0] CH_0 = 8'h30;
    localparam logic [7:0] CH_9 = 8'h39;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] CR   = 8'h0D;

    localparam logic [ERR_W-1:0] ERR_NONE   = 2'b00;
    localparam logic [ERR_W-1:0] ERR_SYNTAX = 2'b01;
    localparam logic [ERR_W-1:0] ERR_RANGE  = 2'b10;

    typedef enum logic [2:0] {
        X_D1,
        X_D2,
        X_ENT,
        Y_D1,
        Y_D2,
        Y_ENT,
        HOLD
    } state_e;

    // True while the parser is building the second operand
    function automatic logic is_y_state(input state_e s);
        return (s == Y_D1) || (s == Y_D2) || (s == Y_ENT);
    endfunction

endpackage

// File: rtl/ascii_char_class.sv
// Combinational ASCII character classifier.
// Ports:
//   char_in   - ASCII character
//   is_digit  - char_in is '0'..'9'
//   is_enter  - char_in is one of the two terminator characters
//   digit_val - numeric value of a digit, 0 otherwise
module ascii_char_class
    import ascii_pkg::*;
#(
    parameter logic [7:0] ENTER_LF = LF,
    parameter logic [7:0] ENTER_CR = CR
) (
    input  logic [7:0] char_in,
    output logic       is_digit,
    output logic       is_enter,
    output logic [3:0] digit_val
);

    always_comb begin
        is_digit  = (char_in >= CH_0) && (char_in <= CH_9);
        is_enter  = (char_in == ENTER_LF) || (char_in == ENTER_CR);
        digit_val = is_digit ? 4'(char_in - CH_0) : 4'd0;
    end

endmodule

// File: rtl/ascii_operand_loader.sv
// Parses two 1-2 digit decimal operands (X then Y, each Enter-terminated)
// from an ASCII character stream and presents them to the adder with a
// valid/ack handshake.
// Ports:
//   clk, reset             - system clock, async active-high reset
//   char_in, char_valid    - incoming character stream
//   char_ready             - loader can accept a character this cycle
//   X, Y                   - latched operands
//   operands_valid         - X/Y pair complete and stable
//   operands_ack           - consumer has taken the pair (HOLD only)
//   err_pulse, err_code    - one-cycle error strobe and sticky error code
module ascii_operand_loader
    import ascii_pkg::*;
#(
    parameter int unsigned W        = 5,
    parameter int unsigned MAX_VAL  = 31,
    parameter logic [7:0]  ENTER_LF = LF,
    parameter logic [7:0]  ENTER_CR = CR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    output logic [W-1:0]     X,
    output logic [W-1:0]     Y,
    output logic             operands_valid,
    input  logic             operands_ack,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_code
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [W-1:0]       x_q, x_d, y_q, y_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_code_q, err_code_d;

    logic               is_digit, is_enter;
    logic [3:0]         digit_val;
    logic               accept;
    logic               in_y;
    state_e             d1_s, d2_s, ent_s;

    ascii_char_class #(
        .ENTER_LF (ENTER_LF),
        .ENTER_CR (ENTER_CR)
    ) u_class (
        .char_in   (char_in),
        .is_digit  (is_digit),
        .is_enter  (is_enter),
        .digit_val (digit_val)
    );

    assign accept = char_valid & ready_q;

    // X and Y share one set of transitions; pick the operand-specific targets
    always_comb begin
        in_y  = is_y_state(state_q);
        d1_s  = in_y ? Y_D1  : X_D1;
        d2_s  = in_y ? Y_D2  : X_D2;
        ent_s = in_y ? Y_ENT : X_ENT;
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= X_D1;
            acc_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            y_q         <= y_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        x_d         = x_q;
        y_d         = y_q;
        valid_d     = valid_q;
        ready_d     = ready_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;

        if (state_q == HOLD) begin
            if (operands_ack) begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = X_D1;
            end
        end else if (accept) begin
            // Enter after at least one digit terminates the current operand
            if (is_enter && (state_q != d1_s)) begin
                acc_d = '0;
                if (acc_q > ACC_W'(MAX_VAL)) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_RANGE;
                    state_d     = d1_s;
                end else if (in_y) begin
                    y_d     = W'(acc_q);
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    state_d = HOLD;
                end else begin
                    x_d     = W'(acc_q);
                    state_d = Y_D1;
                end
            end else if (is_enter) begin
                state_d = state_q;
            end else if (is_digit && (state_q == d1_s)) begin
                acc_d   = ACC_W'(digit_val);
                state_d = d2_s;
            end else if (is_digit && (state_q == d2_s)) begin
                acc_d   = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit_val);
                state_d = ent_s;
            end else begin
                // Non-digit, or a third digit: discard the partial operand
                err_pulse_d = 1'b1;
                err_code_d  = ERR_SYNTAX;
                acc_d       = '0;
                state_d     = d1_s;
            end
        end
    end

    assign char_ready     = ready_q;
    assign X              = x_q;
    assign Y              = y_q;
    assign operands_valid = valid_q;
    assign err_pulse      = err_pulse_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_ascii_operand_loader.sv
module tb_ascii_operand_loader;

    localparam logic [7:0] C_LF = 8'h0A;
    localparam logic [7:0] C_CR = 8'h0D;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [4:0] X, Y;
    logic       operands_valid;
    logic       operands_ack;
    logic       err_pulse;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: operand phase (0 = X, 1 = Y, 2 = pair waiting)
    int       m_phase, m_ndig, m_val, m_x, m_y, m_code;
    bit       m_pulse;

    ascii_operand_loader dut (
        .clk            (clk),
        .reset          (reset),
        .char_in        (char_in),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .X              (X),
        .Y              (Y),
        .operands_valid (operands_valid),
        .operands_ack   (operands_ack),
        .err_pulse      (err_pulse),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0; m_ndig = 0; m_val = 0; m_x = 0; m_y = 0; m_code = 0; m_pulse = 0;
    endtask

    task automatic model_char(input logic [7:0] c);
        m_pulse = 0;
        if (c >= "0" && c <= "9") begin
            if (m_ndig < 2) begin
                m_val = m_val * 10 + int'(c) - 48;
                m_ndig++;
            end else begin
                m_pulse = 1; m_code = 1; m_ndig = 0; m_val = 0;
            end
        end else if (c == C_LF || c == C_CR) begin
            if (m_ndig > 0) begin
                if (m_val > 31) begin
                    m_pulse = 1; m_code = 2;
                end else if (m_phase == 0) begin
                    m_x = m_val; m_phase = 1;
                end else begin
                    m_y = m_val; m_phase = 2;
                end
                m_ndig = 0; m_val = 0;
            end
        end else begin
            m_pulse = 1; m_code = 1; m_ndig = 0; m_val = 0;
        end
    endtask

    // Present one character for one cycle and compare every output afterwards
    task automatic send_char(input logic [7:0] c, input bit ack);
        @(negedge clk);
        char_in      = c;
        char_valid   = 1'b1;
        operands_ack = ack;
        model_char(c);
        @(posedge clk);
        #1;
        char_valid   = 1'b0;
        operands_ack = 1'b0;
        n_checks++;
        if (err_pulse !== m_pulse) begin
            n_errors++;
            $display("FAIL err_pulse char=%h got=%b exp=%b", c, err_pulse, m_pulse);
        end
        n_checks++;
        if (err_code !== 2'(m_code)) begin
            n_errors++;
            $display("FAIL err_code char=%h got=%0d exp=%0d", c, err_code, m_code);
        end
        n_checks++;
        if (operands_valid !== (m_phase == 2)) begin
            n_errors++;
            $display("FAIL operands_valid char=%h got=%b exp=%b", c, operands_valid, m_phase == 2);
        end
        n_checks++;
        if (char_ready !== (m_phase != 2)) begin
            n_errors++;
            $display("FAIL char_ready char=%h got=%b exp=%b", c, char_ready, m_phase != 2);
        end
        n_checks++;
        if (X !== 5'(m_x) || Y !== 5'(m_y)) begin
            n_errors++;
            $display("FAIL operands char=%h got X=%0d Y=%0d exp X=%0d Y=%0d", c, X, Y, m_x, m_y);
        end
    endtask

    task automatic send_num(input int v);
        if (v >= 10) send_char(8'(48 + v / 10), 1'b0);
        send_char(8'(48 + v % 10), 1'b0);
    endtask

    // Wait in HOLD with the given stall, then acknowledge and check release
    task automatic do_ack(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            char_valid = 1'b1;
            char_in    = "7";
            @(posedge clk);
            #1;
            n_checks++;
            if (char_ready !== 1'b0 || operands_valid !== 1'b1 ||
                X !== 5'(m_x) || Y !== 5'(m_y)) begin
                n_errors++;
                $display("FAIL hold_stable got rdy=%b vld=%b X=%0d Y=%0d exp rdy=0 vld=1 X=%0d Y=%0d",
                         char_ready, operands_valid, X, Y, m_x, m_y);
            end
        end
        @(negedge clk);
        char_valid   = 1'b0;
        operands_ack = 1'b1;
        @(posedge clk);
        #1;
        operands_ack = 1'b0;
        m_phase      = 0;
        n_checks++;
        if (operands_valid !== 1'b0 || char_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ack_release got vld=%b rdy=%b exp vld=0 rdy=1", operands_valid, char_ready);
        end
    endtask

    task automatic check_reset_state(input string tag);
        n_checks++;
        if (X !== 5'd0 || Y !== 5'd0 || operands_valid !== 1'b0 || err_pulse !== 1'b0 ||
            err_code !== 2'b00 || char_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s got X=%0d Y=%0d vld=%b pulse=%b code=%0d rdy=%b exp all 0, rdy=1",
                     tag, X, Y, operands_valid, err_pulse, err_code, char_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; char_valid = 1'b0; char_in = 8'h00; operands_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_state");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        send_char("1", 0); send_char("2", 0); send_char(C_LF, 0);
        send_char("0", 0); send_char("9", 0); send_char(C_LF, 0);
        n_checks++;
        if (({1'b0, X} + {1'b0, Y}) !== 6'd21) begin
            n_errors++;
            $display("FAIL basic_sum got=%0d exp=21", {1'b0, X} + {1'b0, Y});
        end
        do_ack(0);
    endtask

    task automatic test_max();
        send_char("3", 0); send_char("1", 0); send_char(C_CR, 0);
        send_char("3", 0); send_char("1", 0); send_char(C_CR, 0);
        n_checks++;
        if (({1'b0, X} + {1'b0, Y}) !== 6'b1_11110) begin
            n_errors++;
            $display("FAIL max_sum got=%b exp=111110", {1'b0, X} + {1'b0, Y});
        end
        do_ack(1);
    endtask

    task automatic test_range();
        send_char(C_LF, 0);
        send_char("4", 0); send_char("5", 0); send_char(C_LF, 0);
        send_char("3", 0); send_char("2", 0); send_char(C_CR, 0);
        send_char("0", 0); send_char("7", 0); send_char(C_LF, 0);
        send_char("2", 0); send_char(C_LF, 0);
        do_ack(0);
    endtask

    task automatic test_syntax();
        send_char("1", 0); send_char("2", 0); send_char(C_LF, 0);
        send_char("A", 0);
        send_char("3", 0); send_char("4", 0); send_char("5", 0);
        send_char("1", 0); send_char("+", 0);
        send_char("6", 0); send_char(C_LF, 0);
        do_ack(0);
    endtask

    task automatic test_hold_stall();
        send_num(19); send_char(C_LF, 0);
        send_num(4);  send_char(C_CR, 0);
        do_ack(5);
    endtask

    task automatic async_reset_pulse(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_state(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_num(31); send_char(C_LF, 0); send_char("2", 0);
        async_reset_pulse("reset_in_y_d2");
        send_char("0", 0); send_char("1", 0); send_char(C_LF, 0);
        send_char("0", 0); send_char("1", 0); send_char(C_LF, 0);
        async_reset_pulse("reset_in_hold");
        send_char("0", 0); send_char("1", 0); send_char(C_LF, 0);
        send_char("0", 0); send_char("1", 0); send_char(C_LF, 0);
        do_ack(0);
    endtask

    // Random character soup, including acks outside HOLD and idle cycles
    task automatic test_random();
        logic [7:0] c;
        int         r;
        for (int i = 0; i < 400; i++) begin
            if (m_phase == 2) begin
                do_ack(int'($urandom_range(0, 3)));
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 60)      c = 8'(48 + $urandom_range(0, 9));
                else if (r < 75) c = C_LF;
                else if (r < 85) c = C_CR;
                else if (r < 92) c = 8'($urandom_range(8'h3A, 8'h7E));
                else             c = 8'($urandom_range(8'h20, 8'h2F));
                send_char(c, ($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 4) == 0) begin
                    @(posedge clk);
                    #1;
                    n_checks++;
                    if (err_pulse !== 1'b0 || err_code !== 2'(m_code)) begin
                        n_errors++;
                        $display("FAIL idle_cycle got pulse=%b code=%0d exp pulse=0 code=%0d",
                                 err_pulse, err_code, m_code);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_range();
        test_syntax();
        test_hold_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
